// File: rtl/hog_window_scheduler.sv
// Raster-band window sequencer for the HOG datapath: issues 5x14 window coordinates one per
// handshake and counts returned result beats. All outputs are registered.
module hog_window_scheduler #(
  parameter int IMG_W    = 638,
  parameter int IMG_H    = 482,
  parameter int WIN_H    = 5,
  parameter int WIN_W    = 14,
  parameter int ROW_STEP = 3,
  parameter int COL_STEP = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_win_ready,
  input  logic       i_res_valid,
  output logic       o_win_valid,
  output logic [8:0] o_win_row,
  output logic [9:0] o_win_col,
  output logic [7:0] o_cnt_row,
  output logic [5:0] o_cnt_col,
  output logic       o_last_col,
  output logic       o_last_win,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int N_BANDS = (IMG_H - WIN_H) / ROW_STEP + 1;
  localparam int N_STEPS = (IMG_W - 1 - (WIN_W - 1)) / COL_STEP + 1;

  localparam logic [9:0]  COL_START = 10'(IMG_W - 1);
  localparam logic [9:0]  COL_DEC   = 10'(COL_STEP);
  localparam logic [8:0]  ROW_INC   = 9'(ROW_STEP);
  localparam logic [5:0]  STEP_PEN  = 6'(N_STEPS - 2);
  localparam logic [7:0]  BAND_LAST = 8'(N_BANDS - 1);
  localparam logic [13:0] RES_TOTAL = 14'(N_BANDS * N_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_win_valid, r_busy, r_done, r_err;
  logic        w_win_valid_nxt, w_busy_nxt, w_done_nxt;
  logic [8:0]  r_win_row;
  logic [9:0]  r_win_col;
  logic [7:0]  r_cnt_row;
  logic [5:0]  r_cnt_col;
  logic        r_last_col, r_last_win;
  logic [13:0] r_res_cnt;

  logic w_busy, w_abort, w_accept, w_fire, w_res_inc, w_res_full_nxt;

  assign w_busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_abort   = i_abort && w_busy;
  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_fire    = r_win_valid && i_win_ready && !w_abort;
  assign w_res_inc = i_res_valid && w_busy && !w_abort;
  // True when the result count will be complete after this edge.
  assign w_res_full_nxt = (r_res_cnt == RES_TOTAL) ||
                          ((r_res_cnt == RES_TOTAL - 14'd1) && w_res_inc);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_win_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_win_valid <= w_win_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_abort)                       w_state_nxt = S_IDLE;
        else if (w_fire && r_last_win)     w_state_nxt = w_res_full_nxt ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_abort)                       w_state_nxt = S_IDLE;
        else if (w_res_full_nxt)           w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_win_valid_nxt = (w_state_nxt == S_RUN);
    w_busy_nxt      = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    w_done_nxt      = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort || w_accept) begin
      r_win_row  <= '0;
      r_win_col  <= COL_START;
      r_cnt_row  <= '0;
      r_cnt_col  <= '0;
      r_last_col <= 1'b0;
      r_last_win <= 1'b0;
    end else if (w_fire && !r_last_win) begin
      if (r_last_col) begin
        r_win_row  <= r_win_row + ROW_INC;
        r_win_col  <= COL_START;
        r_cnt_row  <= r_cnt_row + 8'd1;
        r_cnt_col  <= '0;
        r_last_col <= 1'b0;
        r_last_win <= 1'b0;
      end else begin
        r_win_col  <= r_win_col - COL_DEC;
        r_cnt_col  <= r_cnt_col + 6'd1;
        r_last_col <= (r_cnt_col == STEP_PEN);
        r_last_win <= (r_cnt_col == STEP_PEN) && (r_cnt_row == BAND_LAST);
      end
    end
  end

  // Result counter saturates at the frame total; any further beat flags overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_cnt <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_res_cnt <= '0;
      r_err     <= 1'b0;
    end else if (w_abort) begin
      r_res_cnt <= '0;
    end else if (w_res_inc) begin
      if (r_res_cnt == RES_TOTAL) r_err     <= 1'b1;
      else                        r_res_cnt <= r_res_cnt + 14'd1;
    end
  end

  assign o_win_valid = r_win_valid;
  assign o_win_row   = r_win_row;
  assign o_win_col   = r_win_col;
  assign o_cnt_row   = r_cnt_row;
  assign o_cnt_col   = r_cnt_col;
  assign o_last_col  = r_last_col;
  assign o_last_win  = r_last_win;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_hog_window_scheduler.sv
// Directed bench for hog_window_scheduler: walks full frames against a coordinate model and
// checks backpressure, drain/done timing, overflow, abort and mid-drain reset.
module tb_hog_window_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, abort, win_ready, res_valid;
  logic       win_valid, last_col, last_win, busy, done, err;
  logic [8:0] win_row;
  logic [9:0] win_col;
  logic [7:0] cnt_row;
  logic [5:0] cnt_col;

  always #5 clk = ~clk;

  hog_window_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_win_ready(win_ready), .i_res_valid(res_valid),
    .o_win_valid(win_valid), .o_win_row(win_row), .o_win_col(win_col),
    .o_cnt_row(cnt_row), .o_cnt_col(cnt_col), .o_last_col(last_col),
    .o_last_win(last_win), .o_busy(busy), .o_done(done), .o_err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // {valid, row, col, cnt_row, cnt_col, last_col, last_win, busy}
  localparam logic [63:0] RESET_WIN = {27'd0, 1'b0, 9'd0, 10'd637, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [63:0] VALID_BIT = 64'h1 << 36;

  function automatic logic [63:0] exp_win(input int n);
    int band, step;
    band = n / 53;
    step = n % 53;
    return {27'd0, 1'b1, 9'(3 * band), 10'(637 - 12 * step), 8'(band), 6'(step),
            1'(step == 52), 1'(step == 52 && band == 159), 1'b1};
  endfunction

  function automatic logic [63:0] act_win();
    return {27'd0, win_valid, win_row, win_col, cnt_row, cnt_col, last_col, last_win, busy};
  endfunction

  int idx, res_sent, done_cyc, last_res_cyc, last_fire_cyc;
  bit drain_seen, done_seen, aborted, rst_hit;

  task automatic run_frame(input bit echo, input int stall_at, input int stall_len,
                           input int res_budget, input int start_at, input int abort_at,
                           input bit rst_in_drain);
    logic [4:0] pipe;
    int  stalled;
    bit  fire, rdy, mid_start, ended;
    pipe = '0; stalled = 0; mid_start = 0; ended = 0;
    idx = 0; res_sent = 0; done_cyc = -1; last_res_cyc = -1; last_fire_cyc = -1;
    drain_seen = 0; done_seen = 0; aborted = 0; rst_hit = 0;
    @(negedge clk);
    start = 1'b1; win_ready = 1'b1; res_valid = 1'b0; abort = 1'b0;
    for (int cyc = 0; cyc < 9000; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; res_valid = 1'b0; win_ready = 1'b0;
      if (done) begin
        done_seen = 1; done_cyc = cyc; ended = 1;
        check("done_busy", {win_valid, busy}, 2'b00);
        break;
      end
      if (idx < 8480) begin
        check("win", act_win(), exp_win(idx));
      end else begin
        check("drain_hold", act_win(), exp_win(8479) & ~VALID_BIT);
        drain_seen = 1;
        if (rst_in_drain) begin
          rst = 1'b1; rst_hit = 1; ended = 1;
          break;
        end
      end
      if (idx == abort_at) begin
        abort = 1'b1; win_ready = 1'b1; res_valid = 1'b1; aborted = 1; ended = 1;
        break;
      end
      if (idx == start_at && !mid_start) begin
        start = 1'b1; mid_start = 1;
      end
      rdy = !(idx == stall_at && stalled < stall_len);
      if (!rdy) stalled++;
      win_ready = rdy;
      fire = win_valid && rdy;
      if (fire) begin
        idx++;
        last_fire_cyc = cyc;
      end
      pipe = {pipe[3:0], fire};
      res_valid = echo ? pipe[4] : (res_sent < res_budget);
      if (res_valid) begin
        res_sent++;
        if (res_sent == 8480) last_res_cyc = cyc;
      end
    end
    if (!ended) check("frame_timeout", 1, 0);
  endtask

  initial begin
    bit done_any;
    rst = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_win", act_win(), RESET_WIN);
    check("rst_done_err", {done, err}, 2'b00);
    rst = 1'b0;

    // Frame A: echoed results, 5-cycle stall at col 529, stray start in band 5.
    run_frame(1, 9, 5, 0, 265, -1, 0);
    check("A_done_seen", done_seen, 1);
    check("A_fires", idx, 8480);
    check("A_drain", drain_seen, 1);
    check("A_res_lag", last_res_cyc, last_fire_cyc + 4);
    check("A_done_cyc", done_cyc, last_res_cyc + 1);
    check("A_err", err, 0);
    @(negedge clk);
    check("A_done_pulse", {done, busy, win_valid}, 3'b000);

    // Frame B: last beat lands with the last fire, so RUN goes straight to DONE.
    run_frame(0, -1, 0, 8480, -1, -1, 0);
    check("B_done_seen", done_seen, 1);
    check("B_no_drain", drain_seen, 0);
    check("B_same_cyc", last_res_cyc, last_fire_cyc);
    check("B_done_cyc", done_cyc, last_fire_cyc + 1);
    check("B_err", err, 0);
    @(negedge clk);
    check("B_done_pulse", done, 0);

    // Frame C: 8481 beats before done -> sticky overflow.
    run_frame(0, 100, 1, 8481, -1, -1, 0);
    check("C_done_seen", done_seen, 1);
    check("C_done_cyc", done_cyc, last_fire_cyc + 1);
    check("C_res_sent", res_sent, 8481);
    check("C_err_done", err, 1);
    @(negedge clk);
    check("C_err_idle", {done, busy, err}, 3'b001);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    check("C_err_hold", err, 1);

    // Frame D: abort at fire 1000; start clears err.
    run_frame(1, -1, 0, 0, -1, 1000, 0);
    check("D_aborted", aborted, 1);
    @(negedge clk);
    abort = 1'b0; res_valid = 1'b0;
    check("D_abort_win", act_win(), RESET_WIN);
    check("D_err_clr", err, 0);
    done_any = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      done_any |= done;
    end
    check("D_no_done", done_any, 0);

    // Frame E: restart after abort, then reset while draining.
    run_frame(1, -1, 0, 0, -1, -1, 1);
    check("E_rst_hit", rst_hit, 1);
    @(negedge clk);
    rst = 1'b0;
    check("E_rst_win", act_win(), RESET_WIN);
    check("E_rst_done_err", {done, err}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hog_window_scheduler.md
Name: hog_window_scheduler

Overview:
- Frame-level sequencer that feeds the median-of-median + HOG + sqrt datapath (top) one 5-row x 14-column pixel window per handshake.
- Walks a 638x482 noisy frame in raster bands.
  - Row step 3, rows 0..477.
  - Column step 12, MSB-first column index 637 down to 13.
- Emits window coordinates and band/step counters to the frame-buffer read logic and the datapath.
- Counts returned result beats, detects completion or overflow, and signals frame done.

Parameters:
- IMG_W, 638, input frame width in pixels.
- IMG_H, 482, input frame height in pixels.
- WIN_H, 5, window height (rows).
- WIN_W, 14, window width (columns).
- ROW_STEP, 3, row advance per band.
- COL_STEP, 12, column advance per window.
- N_BANDS, 160, (IMG_H-WIN_H)/ROW_STEP+1.
- N_STEPS, 53, (IMG_W-1-(WIN_W-1))/COL_STEP+1.

Ports:
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle frame start request; honoured only in IDLE.
- abort, in, 1, cancel the current frame; honoured in RUN and DRAIN.
- win_ready, in, 1, downstream accepts the current window.
- res_valid, in, 1, one result beat (4 blocks of 3x3 12-bit) left the datapath.
- win_valid, out, 1, window coordinates valid.
- win_row, out, 9, top row of the window (0..477).
- win_col, out, 10, MSB-side column of the window (637..13, decreasing).
- cnt_row, out, 8, band index 0..N_BANDS-1.
- cnt_col, out, 6, step index within band 0..N_STEPS-1.
- last_col, out, 1, current window is the final step of its band.
- last_win, out, 1, current window is the final window of the frame.
- busy, out, 1, state is RUN or DRAIN.
- done, out, 1, one-cycle pulse: frame complete.
- err, out, 1, sticky: result-beat overflow.

Behaviour:
- Reset values: state IDLE, win_valid=0, win_row=0, win_col=IMG_W-1 (637), cnt_row=0, cnt_col=0, last_col=0, last_win=0, busy=0, done=0, err=0, internal fire counter=0, res counter=0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> next cycle enter RUN with win_valid=1, coordinates (0,637), counters (0,0). Start-to-first-valid latency is 1 cycle.
  - On the same edge, clear err, the fire counter and the res counter.
- Fire = win_valid & win_ready.
  - While win_valid=1 and win_ready=0, all coordinate and flag outputs hold stable.
  - win_valid never drops without a fire, except on abort or rst.
- On fire, not the last window of its band (cnt_col<N_STEPS-1): win_col -= COL_STEP, cnt_col += 1.
- On fire at cnt_col=N_STEPS-1 (win_col=13): wrap to win_col=637, cnt_col=0, win_row += ROW_STEP, cnt_row += 1.
- last_col = (cnt_col==N_STEPS-1). last_win = last_col & (cnt_row==N_BANDS-1).
- Fire on last_win (477,13,159,52): next cycle win_valid=0, enter DRAIN. Coordinates hold their final values.
- Back-to-back fires are sustained at 1 window/cycle with win_ready held high.
- Res counter (14-bit, total N_BANDS*N_STEPS=8480):
  - Increments on res_valid in RUN or DRAIN.
  - res_valid in IDLE or DONE is ignored.
- DRAIN -> DONE when the res counter reaches 8480. This includes the case where the 8480th beat arrives in the same cycle as the last fire; then go RUN -> DONE directly.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start in DONE is ignored.
- Overflow: res_valid when the counter is already 8480 sets err=1; the counter saturates. err stays sticky until the next accepted start or rst.
- abort in RUN or DRAIN:
  - Next cycle: IDLE, win_valid=0, coordinates and counters return to reset values, done not pulsed.
  - abort has priority over fire and res_valid in the same cycle.
- start while busy is ignored. Simultaneous start and abort in IDLE: start wins (abort is meaningless in IDLE).
- rst mid-frame returns every output to its reset value at the next edge, regardless of state.

Test Plan:
- rst, then start with win_ready=1:
  - First window (0,637,0,0) one cycle after start.
  - win_col steps 637,625,...,13.
  - Beat 53 has last_col=1.
  - Beat 54 is (3,637,1,0).
- Backpressure: drop win_ready for 5 cycles at beat 10 (win_col=529):
  - Outputs stable for those 5 cycles.
  - Next fire advances to 517. No window skipped or duplicated.
- Full frame with win_ready=1 and res_valid echoing fires 4 cycles later:
  - 8480 fires; last window (477,13,159,52) with last_win=1.
  - DRAIN entered.
  - done pulses one cycle after the 8480th res_valid; busy falls with it; err=0.
- Abort asserted at fire 1000 (win_ready high):
  - Next cycle win_valid=0, IDLE, win_col=637, cnt_row=0, done never pulses.
  - A new start restarts at (0,637,0,0).
- Inject 8481 res_valid pulses before done:
  - err=1 and stays set through DONE and IDLE.
  - Next start clears it.
- Pulse start during RUN at band 5: no effect on the sequence.
- Assert rst during DRAIN: all outputs at reset values next cycle.
